// File: rtl/pkt_capture.sv
// Packet capture front end: takes Avalon-ST beats from the MAC, writes captured beats to the data FIFO and hands a descriptor to wr_ctrl.
// Optional snap-length truncation is enabled by defining PKT_CAPTURE_SNAPLEN_EN.
module pkt_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] st_data,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  input  logic [1:0]  st_empty,
  output logic        st_ready,
  output logic [31:0] fifo_in,
  output logic        wrreq,
  input  logic        almost_full,
  input  logic        enable,
  input  logic [31:0] seconds,
  input  logic [31:0] nanoseconds,
  output logic [31:0] ts_sec,
  output logic [31:0] ts_nsec,
  output logic [15:0] pkt_len,
  output logic        desc_valid,
  input  logic        desc_ready,
`ifdef PKT_CAPTURE_SNAPLEN_EN
  input  logic [15:0] snaplen,
  output logic [15:0] orig_len,
`endif
  output logic [31:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DISCARD = 2'd2,
    DESC    = 2'd3
  } state_t;

  state_t      state_r;
  logic        ready_en_r;
  logic [31:0] fifo_in_r;
  logic        wrreq_r;
  logic [31:0] ts_sec_r;
  logic [31:0] ts_nsec_r;
  logic [15:0] count_r;
  logic [15:0] pkt_len_r;
  logic        desc_valid_r;
  logic [31:0] drop_cnt_r;

  logic        ready_s;
  logic        accept_s;
  logic [15:0] base_s;
  logic [15:0] next_count_s;
  logic [15:0] len_s;
  logic        keep_s;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

  function automatic logic [15:0] beat_bytes(input logic eop, input logic [1:0] empty);
    if (eop) begin
      return 16'd4 - {14'd0, empty};
    end else begin
      return 16'd4;
    end
  endfunction

  // Sink ready per state; held low until the first edge after reset release.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = ready_en_r;
      DISCARD: ready_s = ready_en_r;
      CAPTURE: ready_s = ready_en_r & ~almost_full;
      DESC:    ready_s = 1'b0;
      default: ready_s = 1'b0;
    endcase
  end

  assign accept_s = st_valid & ready_s;

  // Byte count after this beat; a beat taken in IDLE starts a fresh count.
  always_comb begin
    if (state_r == IDLE) begin
      base_s = 16'd0;
    end else begin
      base_s = count_r;
    end
    next_count_s = sat_add(base_s, beat_bytes(st_eop, st_empty));
  end

`ifdef PKT_CAPTURE_SNAPLEN_EN
  logic [15:0] orig_len_r;

  // Beats starting at or past the snap length are swallowed; snaplen of zero disables truncation.
  always_comb begin
    if (snaplen == 16'd0) begin
      keep_s = 1'b1;
      len_s  = next_count_s;
    end else begin
      keep_s = (base_s < snaplen);
      if (next_count_s < snaplen) begin
        len_s = next_count_s;
      end else begin
        len_s = snaplen;
      end
    end
  end

  assign orig_len = orig_len_r;
`else
  // Without truncation every captured beat is written and the length is the raw count.
  always_comb begin
    keep_s = 1'b1;
    len_s  = next_count_s;
  end
`endif

  // Capture FSM with registered FIFO write, timestamp, length and descriptor outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      ready_en_r   <= 1'b0;
      fifo_in_r    <= 32'd0;
      wrreq_r      <= 1'b0;
      ts_sec_r     <= 32'd0;
      ts_nsec_r    <= 32'd0;
      count_r      <= 16'd0;
      pkt_len_r    <= 16'd0;
      desc_valid_r <= 1'b0;
      drop_cnt_r   <= 32'd0;
`ifdef PKT_CAPTURE_SNAPLEN_EN
      orig_len_r   <= 16'd0;
`endif
    end else begin
      ready_en_r <= 1'b1;
      wrreq_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && st_sop) begin
            if (enable) begin
              ts_sec_r  <= seconds;
              ts_nsec_r <= nanoseconds;
              count_r   <= next_count_s;
              pkt_len_r <= len_s;
`ifdef PKT_CAPTURE_SNAPLEN_EN
              orig_len_r <= next_count_s;
`endif
              wrreq_r   <= keep_s;
              if (keep_s) begin
                fifo_in_r <= st_data;
              end else begin
                fifo_in_r <= fifo_in_r;
              end
              state_r <= st_eop ? DESC : CAPTURE;
            end else begin
              drop_cnt_r <= drop_cnt_r + 32'd1;
              state_r    <= st_eop ? IDLE : DISCARD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CAPTURE: begin
          if (accept_s) begin
            count_r   <= next_count_s;
            pkt_len_r <= len_s;
`ifdef PKT_CAPTURE_SNAPLEN_EN
            orig_len_r <= next_count_s;
`endif
            wrreq_r   <= keep_s;
            if (keep_s) begin
              fifo_in_r <= st_data;
            end else begin
              fifo_in_r <= fifo_in_r;
            end
            state_r <= st_eop ? DESC : CAPTURE;
          end else begin
            state_r <= CAPTURE;
          end
        end
        DISCARD: begin
          if (accept_s && st_eop) begin
            state_r <= IDLE;
          end else begin
            state_r <= DISCARD;
          end
        end
        DESC: begin
          // One dead cycle lets the last written word reach the FIFO output first.
          if (!desc_valid_r) begin
            desc_valid_r <= 1'b1;
          end else if (desc_ready) begin
            desc_valid_r <= 1'b0;
            state_r      <= IDLE;
          end else begin
            desc_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          desc_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready   = ready_s;
  assign fifo_in    = fifo_in_r;
  assign wrreq      = wrreq_r;
  assign ts_sec     = ts_sec_r;
  assign ts_nsec    = ts_nsec_r;
  assign pkt_len    = pkt_len_r;
  assign desc_valid = desc_valid_r;
  assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_pkt_capture.sv
// Scoreboard bench for pkt_capture: expected FIFO writes and descriptors are queued as beats are accepted.
module tb_pkt_capture;

  logic        clk;
  logic        reset;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_sop;
  logic        st_eop;
  logic [1:0]  st_empty;
  logic        st_ready;
  logic [31:0] fifo_in;
  logic        wrreq;
  logic        almost_full;
  logic        enable;
  logic [31:0] seconds;
  logic [31:0] nanoseconds;
  logic [31:0] ts_sec;
  logic [31:0] ts_nsec;
  logic [15:0] pkt_len;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] drop_cnt;
`ifdef PKT_CAPTURE_SNAPLEN_EN
  logic [15:0] snaplen;
  logic [15:0] orig_len;
`endif

  pkt_capture dut (
    .clk(clk), .reset(reset),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty),
    .st_ready(st_ready), .fifo_in(fifo_in), .wrreq(wrreq), .almost_full(almost_full),
    .enable(enable), .seconds(seconds), .nanoseconds(nanoseconds),
    .ts_sec(ts_sec), .ts_nsec(ts_nsec), .pkt_len(pkt_len),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
`ifdef PKT_CAPTURE_SNAPLEN_EN
    .snaplen(snaplen), .orig_len(orig_len),
`endif
    .drop_cnt(drop_cnt)
  );

  typedef struct { logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [15:0] len; logic [15:0] olen; logic [31:0] sec; logic [31:0] nsec; int cyc; } desc_t;

  wr_t   wr_q[$];
  desc_t desc_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    snap = 0;
  int    exp_drop = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    seconds = 32'h100;
    nanoseconds = 32'h5000;
    forever begin
      @(posedge clk);
      #1;
      seconds = seconds + 32'd1;
      nanoseconds = nanoseconds + 32'd7;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every write and descriptor, checks handshake behaviour.
  logic        dv_prev = 1'b0;
  logic        dr_prev = 1'b0;
  logic [15:0] len_prev = 16'd0;
  logic [31:0] sec_prev = 32'd0;
  wr_t   w;
  desc_t d;
  always @(negedge clk) begin
    if (reset) begin
      if (wrreq) begin
        if (wr_q.size() == 0) begin
          check_eq("wr_unexpected", 64'd1, 64'd0);
        end else begin
          w = wr_q.pop_front();
          check_eq("wr_data", 64'(fifo_in), 64'(w.data));
          check_eq("wr_cycle", 64'(cyc), 64'(w.cyc));
        end
      end
      if (desc_valid && !dv_prev) begin
        if (desc_q.size() == 0) begin
          check_eq("desc_unexpected", 64'd1, 64'd0);
        end else begin
          d = desc_q.pop_front();
          check_eq("pkt_len", 64'(pkt_len), 64'(d.len));
          check_eq("ts_sec", 64'(ts_sec), 64'(d.sec));
          check_eq("ts_nsec", 64'(ts_nsec), 64'(d.nsec));
          check_eq("desc_cycle", 64'(cyc), 64'(d.cyc));
`ifdef PKT_CAPTURE_SNAPLEN_EN
          check_eq("orig_len", 64'(orig_len), 64'(d.olen));
`endif
        end
      end
      if (dv_prev && dr_prev) check_eq("desc_release", 64'(desc_valid), 64'd0);
      if (dv_prev && !dr_prev) begin
        check_eq("desc_hold", 64'(desc_valid), 64'd1);
        check_eq("len_stable", 64'(pkt_len), 64'(len_prev));
        check_eq("ts_stable", 64'(ts_sec), 64'(sec_prev));
      end
    end
    dv_prev  = desc_valid;
    dr_prev  = desc_ready;
    len_prev = pkt_len;
    sec_prev = ts_sec;
  end

  task automatic drive_beat(input logic [31:0] data, input logic sop, input logic eop, input logic [1:0] emp,
                            output int acc_cyc, output logic [31:0] s, output logic [31:0] ns, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    acc_cyc = 0;
    s = 32'd0;
    ns = 32'd0;
    st_valid = 1'b1; st_data = data; st_sop = sop; st_eop = eop; st_empty = emp;
    while (!acc && waits < 64) begin
      @(negedge clk);
      acc = st_ready;
      acc_cyc = cyc;
      s = seconds;
      ns = nanoseconds;
      @(posedge clk);
      #1;
      if (!acc) waits = waits + 1;
    end
    if (!acc) check_eq("accept_timeout", 64'd0, 64'd1);
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 2'd0;
  endtask

  // Sends one packet and queues the writes/descriptor the bench expects from it.
  task automatic send_pkt(input int nb, input logic [31:0] base, input logic [1:0] last_empty,
                          input logic en, input int af_beat, input logic drop_en_mid);
    int cnt, bytes, acc_cyc, waits;
    logic [31:0] s, ns, sop_s, sop_ns;
    logic eop;
    logic [1:0] emp;
    cnt = 0; sop_s = 32'd0; sop_ns = 32'd0;
    for (int i = 0; i < nb; i++) begin
      eop = (i == nb - 1);
      emp = eop ? last_empty : 2'd0;
      if (i == 0) enable = en;
      else if (drop_en_mid) enable = 1'b0;
      if (i == af_beat) begin
        almost_full = 1'b1;
        st_valid = 1'b1; st_data = base + 32'(i); st_sop = 1'b0; st_eop = eop; st_empty = emp;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_eq("ready_af", 64'(st_ready), 64'd0);
          @(posedge clk);
          #1;
        end
        almost_full = 1'b0;
      end
      drive_beat(base + 32'(i), (i == 0), eop, emp, acc_cyc, s, ns, waits);
      if (en) begin
        if (snap == 0 || cnt < snap) wr_q.push_back('{data: base + 32'(i), cyc: acc_cyc + 1});
        bytes = eop ? 4 - int'(emp) : 4;
        cnt = (cnt + bytes > 65535) ? 65535 : cnt + bytes;
        if (i == 0) begin sop_s = s; sop_ns = ns; end
        if (eop) desc_q.push_back('{len: (snap != 0 && cnt > snap) ? 16'(snap) : 16'(cnt),
                                    olen: 16'(cnt), sec: sop_s, nsec: sop_ns, cyc: acc_cyc + 2});
      end else begin
        check_eq("ready_discard", 64'(waits), 64'd0);
        if (i == 0) exp_drop = exp_drop + 1;
      end
    end
    enable = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((desc_q.size() != 0 || wr_q.size() != 0 || desc_valid) && n < limit) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check_eq("drain_timeout", 64'(n < limit), 64'd1);
  endtask

  initial begin
    int acc_cyc, waits, n;
    logic [31:0] s, ns;
    reset = 1'b0; st_valid = 1'b0; st_data = 32'd0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 2'd0;
    almost_full = 1'b0; enable = 1'b1; desc_ready = 1'b1;
`ifdef PKT_CAPTURE_SNAPLEN_EN
    snaplen = 16'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(st_ready), 64'd0);
    check_eq("rst_wrreq", 64'(wrreq), 64'd0);
    check_eq("rst_desc_valid", 64'(desc_valid), 64'd0);
    check_eq("rst_outputs", {32'(fifo_in | ts_sec | ts_nsec), 16'd0, pkt_len}, 64'd0);
    check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b1;
    #1;
    check_eq("ready_before_edge", 64'(st_ready), 64'd0);
    @(posedge clk);
    #1;
    check_eq("ready_after_release", 64'(st_ready), 64'd1);

    send_pkt(8, 32'd10, 2'd0, 1'b1, -1, 1'b0);
    wait_idle(20);
    send_pkt(3, 32'hA000, 2'd3, 1'b1, -1, 1'b0);
    wait_idle(20);
    send_pkt(4, 32'hB000, 2'd0, 1'b0, -1, 1'b0);
    check_eq("drop_cnt_1", 64'(drop_cnt), 64'(exp_drop));
    send_pkt(1, 32'hB100, 2'd2, 1'b0, -1, 1'b0);
    check_eq("drop_cnt_2", 64'(drop_cnt), 64'(exp_drop));
    send_pkt(5, 32'hC000, 2'd1, 1'b1, -1, 1'b1);
    wait_idle(20);
    send_pkt(6, 32'hD000, 2'd2, 1'b1, 3, 1'b0);
    wait_idle(20);
    send_pkt(1, 32'hD100, 2'd1, 1'b1, -1, 1'b0);
    wait_idle(20);

    desc_ready = 1'b0;
    send_pkt(2, 32'hE000, 2'd0, 1'b1, -1, 1'b0);
    fork
      send_pkt(4, 32'hE100, 2'd1, 1'b1, -1, 1'b0);
      begin
        n = 0;
        while (!desc_valid && n < 10) begin
          @(posedge clk);
          #1;
          n = n + 1;
        end
        check_eq("desc_wait", 64'(desc_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check_eq("ready_in_desc", 64'(st_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        desc_ready = 1'b1;
      end
    join
    wait_idle(20);

    send_pkt(16400, 32'h10000, 2'd0, 1'b1, -1, 1'b0);
    wait_idle(20);

`ifdef PKT_CAPTURE_SNAPLEN_EN
    snap = 8;
    snaplen = 16'd8;
    send_pkt(8, 32'hF000, 2'd0, 1'b1, -1, 1'b0);
    wait_idle(20);
    snap = 0;
    snaplen = 16'd0;
`endif

    drive_beat(32'h7000, 1'b1, 1'b0, 2'd0, acc_cyc, s, ns, waits);
    wr_q.push_back('{data: 32'h7000, cyc: acc_cyc + 1});
    drive_beat(32'h7001, 1'b0, 1'b0, 2'd0, acc_cyc, s, ns, waits);
    wr_q.push_back('{data: 32'h7001, cyc: acc_cyc + 1});
    @(posedge clk);
    #1;
    reset = 1'b0;
    #3;
    check_eq("midpkt_rst_ready", 64'(st_ready), 64'd0);
    check_eq("midpkt_rst_drop", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("midpkt_no_pending", 64'(wr_q.size() + desc_q.size()), 64'd0);
    check_eq("midpkt_no_desc", 64'(desc_valid), 64'd0);
    send_pkt(2, 32'h7100, 2'd0, 1'b1, -1, 1'b0);
    wait_idle(20);

    repeat (5) @(posedge clk);
    #1;
    check_eq("queues_empty", 64'(wr_q.size() + desc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
